ctrl_code_search: RTL and testbench

- Sequential inverse of the 7-in/26-out control decoder: given a requested control-vector pattern, finds the lowest opcode whose decode matches it.
- Drives candidate opcodes into an external combinational copy of the control decoder, one per cycle, and compares the returned decode word against a masked target.
- Sits between the test/compile flow and the decoder. Used to regenerate opcodes from control-line requirements.

---
 rtl/ctrl_code_search.sv | 169 ++++++++++++++++
 tb/tb_ctrl_code_search.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_code_search.sv
// ctrl_code_search: sequential inverse of the control decoder.
// Finds the lowest opcode whose decode matches a masked target.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   flush                  synchronous abort back to IDLE
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_mask, req_value    1 = line checked; required line levels
//   code_o                 candidate opcode sent to the external decoder
//   dec_i                  decode of code_o, same cycle
//   rsp_valid/rsp_ready    response handshake
//   rsp_found, rsp_code    match flag and lowest matching opcode (0 if none)
//
// Optional: define CTRL_SEARCH_CACHE_EN for a one-entry result cache.
//   A repeated request then skips the scan.
module ctrl_code_search #(
    parameter int CODE_W = 7,
    parameter int DEC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DEC_W-1:0]  req_mask,
    input  logic [DEC_W-1:0]  req_value,
    output logic [CODE_W-1:0] code_o,
    input  logic [DEC_W-1:0]  dec_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic [CODE_W-1:0] rsp_code
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    localparam logic [CODE_W-1:0] LAST = '1;

    state_t              r_state;
    logic [CODE_W-1:0]   r_cnt;
    logic [DEC_W-1:0]    r_mask;
    logic [DEC_W-1:0]    r_value;
    logic                r_rsp_valid;
    logic                r_found;
    logic [CODE_W-1:0]   r_code;

    logic                w_match;
    logic                w_done;
    logic                w_hit;
    logic                w_c_found;
    logic [CODE_W-1:0]   w_c_code;

    // Lines outside the mask never block a match.
    assign w_match = (((dec_i ^ r_value) & r_mask) == '0);

    // Scan finishes this cycle, with or without a match.
    assign w_done = (r_state == SCAN) && (w_match || (r_cnt == LAST));

`ifdef CTRL_SEARCH_CACHE_EN
    logic                r_c_valid;
    logic [DEC_W-1:0]    r_c_mask;
    logic [DEC_W-1:0]    r_c_value;
    logic                r_c_found;
    logic [CODE_W-1:0]   r_c_code;

    assign w_hit = r_c_valid
                && (req_mask == r_c_mask)
                && (req_value == r_c_value);
    assign w_c_found = r_c_found;
    assign w_c_code  = r_c_code;

    // Filled with whatever the scan concludes, found or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_mask  <= '0;
            r_c_value <= '0;
            r_c_found <= 1'b0;
            r_c_code  <= '0;
        end else if (flush) begin
            r_c_valid <= 1'b0;
        end else if (w_done) begin
            r_c_valid <= 1'b1;
            r_c_mask  <= r_mask;
            r_c_value <= r_value;
            r_c_found <= w_match;
            r_c_code  <= w_match ? r_cnt : '0;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_c_found = 1'b0;
    assign w_c_code  = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_rsp_valid <= 1'b0;
            r_found     <= 1'b0;
            r_code      <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_found     <= 1'b0;
            r_code      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_mask  <= req_mask;
                        r_value <= req_value;
                        r_cnt   <= '0;
                        if (w_hit) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_found     <= w_c_found;
                            r_code      <= w_c_code;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_match) begin
                        r_code      <= r_cnt;
                        r_found     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= RESP;
                    end else if (r_cnt == LAST) begin
                        r_code      <= '0;
                        r_found     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Counter is cleared outside SCAN, so it doubles as the opcode output.
    assign code_o    = r_cnt;
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_found = r_found;
    assign rsp_code  = r_code;

endmodule

// File: tb/tb_ctrl_code_search.sv
// tb_ctrl_code_search: scoreboard bench for ctrl_code_search.
// Uses an identity decoder model: dec_i = zero-extended code_o.
module tb_ctrl_code_search;

    localparam int CODE_W = 7;
    localparam int DEC_W  = 26;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [DEC_W-1:0]  req_mask;
    logic [DEC_W-1:0]  req_value;
    logic [CODE_W-1:0] code_o;
    logic [DEC_W-1:0]  dec_i;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_found;
    logic [CODE_W-1:0] rsp_code;

    typedef struct {
        logic              found;
        logic [CODE_W-1:0] code;
        int                lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    ctrl_code_search #(
        .CODE_W(CODE_W),
        .DEC_W (DEC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mask (req_mask),
        .req_value(req_value),
        .code_o   (code_o),
        .dec_i    (dec_i),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_found(rsp_found),
        .rsp_code (rsp_code)
    );

    assign dec_i = {{(DEC_W-CODE_W){1'b0}}, code_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic drive_accept(input logic [DEC_W-1:0] m,
                                input logic [DEC_W-1:0] v);
        check("req_ready_pre", {31'd0, req_ready}, 32'd1);
        req_mask  = m;
        req_value = v;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("code_o_accept", {25'd0, code_o}, 32'd0);
    endtask

    task automatic send(input logic [DEC_W-1:0] m,
                        input logic [DEC_W-1:0] v,
                        input logic             f,
                        input logic [CODE_W-1:0] c,
                        input int               lat);
        exp_t e;
        e.found = f;
        e.code  = c;
        e.lat   = lat;
        sb.push_back(e);
        drive_accept(m, v);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   edges;
        bit   seen;
        e     = sb.pop_front();
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (rsp_valid) begin
                seen = 1'b1;
                check("code_o_resp", {25'd0, code_o}, 32'd0);
            end else begin
                check("code_o_scan", {25'd0, code_o}, edges);
            end
        end
        if (!seen) begin
            check("timeout", edges, e.lat);
            return;
        end
        check("latency", edges, e.lat);
        check("found", {31'd0, rsp_found}, {31'd0, e.found});
        check("code", {25'd0, rsp_code}, {25'd0, e.code});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_code", {25'd0, rsp_code}, {25'd0, e.code});
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int hit_lat;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_mask  = '0;
        req_value = '0;
        rsp_ready = 1'b0;

`ifdef CTRL_SEARCH_CACHE_EN
        hit_lat = 1;
`else
        hit_lat = 6;
`endif

        #12;
        check("rst_code_o", {25'd0, code_o}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_found", {31'd0, rsp_found}, 32'd0);
        check("rst_code", {25'd0, rsp_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // Match at code 5.
        send(26'h7F, 26'h05, 1'b1, 7'd5, 6);
        collect(0);

        // Same request again: cache hit when enabled.
        send(26'h7F, 26'h05, 1'b1, 7'd5, hit_lat);
        collect(0);

        // flush with req_valid in IDLE: request ignored, cache dropped.
        req_mask  = 26'h7F;
        req_value = 26'h05;
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_idle_nv", {31'd0, rsp_valid}, 32'd0);
        end
        send(26'h7F, 26'h05, 1'b1, 7'd5, 6);
        collect(0);

        // Unreachable bit: not found after full scan.
        send(26'h80, 26'h80, 1'b0, 7'd0, 128);
        collect(0);

        // Empty mask matches code 0; hold the response.
        send(26'h0, 26'h0, 1'b1, 7'd0, 1);
        collect(10);

        // flush at scan cycle 3.
        drive_accept(26'h7F, 26'h40);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_flush_code", {25'd0, code_o}, 32'd3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_valid", {31'd0, rsp_valid}, 32'd0);
        check("flush_code_o", {25'd0, code_o}, 32'd0);
        check("flush_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("flush_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        send(26'h7F, 26'h40, 1'b1, 7'h40, 65);
        collect(0);

        // Async reset mid-scan.
        drive_accept(26'h7F, 26'h05);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_code", {25'd0, code_o}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_code_o", {25'd0, code_o}, 32'd0);
        check("arst_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_found", {31'd0, rsp_found}, 32'd0);
        check("arst_code", {25'd0, rsp_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        send(26'h7F, 26'h05, 1'b1, 7'd5, 6);
        collect(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
